// File: rtl/tx_campioni.sv
// tx_campioni: streams one block of NumCampioni bytes from sample memory over a four-phase dav_/rfd handshake
module tx_campioni #(
  parameter int NumCampioni = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  enne,
  output logic [13:0] a13_a0,
  input  logic [7:0]  d7_d0,
  output logic [7:0]  dato,
  output logic        dav_,
  input  logic        rfd,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, READ, WAITRFD, WAITACK, NEXT} state_t;
  localparam logic [10:0] NC = 11'(NumCampioni);
  state_t      state_q;
  logic [10:0] count_q;
  logic [13:0] addr_q;
  logic [7:0]  dato_q;
  logic        dav_q;
  logic        busy_q;
  assign a13_a0 = addr_q;
  assign dato   = dato_q;
  assign dav_   = dav_q;
  assign busy   = busy_q;
  // block sequencer: read a byte, offer it, wait for rfd high then low, advance
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= NC;
      addr_q  <= 14'h0000;
      dato_q  <= 8'h00;
      dav_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= {enne, 10'b0};
          count_q <= NC;
          busy_q  <= 1'b1;
          state_q <= READ;
        end
        READ: begin
          dato_q  <= d7_d0;
          state_q <= WAITRFD;
        end
        WAITRFD: if (rfd) begin
          dav_q   <= 1'b0;
          state_q <= WAITACK;
        end
        WAITACK: if (!rfd) begin
          dav_q   <= 1'b1;
          state_q <= NEXT;
        end
        NEXT: if (count_q == 11'd1) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          addr_q  <= addr_q + 14'd1;
          count_q <= count_q - 11'd1;
          state_q <= READ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_campioni.sv
// tb_tx_campioni: scoreboard bench for tx_campioni with a 1024-sample and a 4-sample instance
module tb_tx_campioni;
  logic        clock, reset, start, rfd, sel;
  logic [3:0]  enne;
  logic [13:0] a1, a4, a_s;
  logic [7:0]  d1, d4, dato1, dato4, dato_s;
  logic        dav1, dav4, dav_s, busy1, busy4, busy_s;
  logic        start1, start4, rfd1, rfd4;
  logic [21:0] q[$];
  int          checks = 0;
  int          passes = 0;

  function automatic logic [7:0] mem(input logic [13:0] a);
    return a[7:0] ^ {a[13:10], a[13:10]} ^ 8'h5A;
  endfunction

  assign d1 = mem(a1);
  assign d4 = a4[7:0];
  assign start1 = !sel && start;
  assign start4 = sel && start;
  assign rfd1 = !sel && rfd;
  assign rfd4 = sel && rfd;
  assign a_s = sel ? a4 : a1;
  assign dato_s = sel ? dato4 : dato1;
  assign dav_s = sel ? dav4 : dav1;
  assign busy_s = sel ? busy4 : busy1;

  tx_campioni #(.NumCampioni(1024)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .enne(enne), .a13_a0(a1),
    .d7_d0(d1), .dato(dato1), .dav_(dav1), .rfd(rfd1), .busy(busy1));

  tx_campioni #(.NumCampioni(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .enne(enne), .a13_a0(a4),
    .d7_d0(d4), .dato(dato4), .dav_(dav4), .rfd(rfd4), .busy(busy4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_dav(input logic v, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dav_s === v) break;
    end
    chk(tag, dav_s, v);
  endtask

  task automatic go(input logic [3:0] e, input int n);
    logic [13:0] ad;
    enne = e;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      ad = {e, 10'b0} + 14'(i);
      q.push_back({ad, sel ? ad[7:0] : mem(ad)});
    end
    @(negedge clock);
    start = 1'b0;
    chk("busy_on_start", busy_s, 1);
    chk("base_addr", a_s, {e, 10'b0});
  endtask

  task automatic consume(input int n, input int dly, input int hold, input int poke_at);
    logic [21:0] e;
    logic [7:0] held;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < dly; k++) begin
        @(negedge clock);
        start = (s == poke_at) && (k == 0);
        if (s == poke_at) enne = 4'hA;
        chk("dav_idle", dav_s, 1);
      end
      start = 1'b0;
      rfd = 1'b1;
      wait_dav(1'b0, "dav_fall_timeout");
      chk("q_nonempty", q.size() > 0, 1);
      e = q.size() > 0 ? q.pop_front() : 22'h0;
      chk("dato", dato_s, e[7:0]);
      chk("addr", a_s, e[21:8]);
      held = dato_s;
      for (int k = 0; k < hold; k++) begin
        @(negedge clock);
        chk("dav_hold", dav_s, 0);
        chk("dato_stable", dato_s, held);
      end
      rfd = 1'b0;
      wait_dav(1'b1, "dav_rise_timeout");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rfd = 1'b0; enne = 4'h0; sel = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_dav", dav1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_dato", dato1, 0);
    chk("rst_addr", a1, 0);
    chk("rst_dav4", dav4, 1);
    chk("rst_busy4", busy4, 0);
    // full block, always-ready consumer
    go(4'h3, 1024);
    consume(1024, 1, 1, -1);
    chk("busy_in_next", busy1, 1);
    @(negedge clock);
    chk("busy_done", busy1, 0);
    chk("last_addr", a1, 14'h0FFF);
    chk("q_empty", q.size(), 0);
    // slow consumer, with a stray start and enne change at sample 10
    go(4'h7, 1024);
    consume(12, 5, 3, 10);
    chk("still_busy", busy1, 1);
    // reset while dav_ is low
    rfd = 1'b1;
    wait_dav(1'b0, "dav_fall_before_reset");
    chk("addr_in_block7", a1, 14'h1C0C);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rfd = 1'b0;
    chk("mid_rst_dav", dav1, 1);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_addr", a1, 0);
    chk("mid_rst_dato", dato1, 0);
    q.delete();
    repeat (3) @(negedge clock);
    chk("no_resume", busy1, 0);
    go(4'h2, 1024);
    consume(3, 1, 1, -1);
    reset = 1'b1;
    @(negedge clock);
    q.delete();
    // reset and start together
    start = 1'b1;
    enne = 4'h1;
    @(negedge clock);
    chk("rst_start_busy", busy1, 0);
    chk("rst_start_dav", dav1, 1);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("idle_busy", busy1, 0);
    @(negedge clock);
    chk("idle_addr", a1, 0);
    // four-sample instance, start coinciding with the NEXT->IDLE cycle
    sel = 1'b1;
    go(4'hF, 4);
    consume(4, 1, 1, -1);
    chk("busy4_in_next", busy4, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy4_done", busy4, 0);
    chk("last_addr4", a4, 14'h3C03);
    @(negedge clock);
    chk("late_start_ignored", busy4, 0);
    chk("dav4_idle", dav4, 1);
    chk("q4_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tx_campioni.md
TX_CAMPIONI -- requirements
Module: tx_campioni

Parameters
REQ-001 The block SHALL have parameter NumCampioni, default 1024, giving the number of samples per block; legal range is 1..1024.

Interface
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to transmit one block; sampled only in IDLE.
REQ-005 The block SHALL have port enne, input, 4 bits: block number; sampled only when start is accepted.
REQ-006 The block SHALL have port a13_a0, output, 14 bits: sample-memory read address (registered).
REQ-007 The block SHALL have port d7_d0, input, 8 bits: memory read data, combinational from a13_a0, valid in the cycle after a13_a0 changes.
REQ-008 The block SHALL have port dato, output, 8 bits: sample byte offered to the consumer (registered).
REQ-009 The block SHALL have port dav_, output, 1 bit: data valid, active low (registered).
REQ-010 The block SHALL have port rfd, input, 1 bit: consumer ready-for-data, active high.
REQ-011 The block SHALL have port busy, output, 1 bit: high from start acceptance until the last handshake completes (registered).

Function
REQ-012 The block SHALL implement the states IDLE, READ, WAITRFD, WAITACK and NEXT, plus an 11-bit sample counter COUNT.
REQ-013 In IDLE with start=1, the block SHALL load a13_a0 with {enne, 10'b0}, load COUNT with NumCampioni, set busy=1 and go to READ; with start=0 it SHALL stay in IDLE.
REQ-014 In READ, the block SHALL load dato with d7_d0 and go to WAITRFD.
REQ-015 In WAITRFD, the block SHALL hold dav_=1 while rfd=0; on rfd=1 it SHALL set dav_=0 and go to WAITACK, and dato SHALL already be stable for at least one cycle.
REQ-016 In WAITACK, the block SHALL hold dav_=0 and dato while rfd=1; on rfd=0 it SHALL set dav_=1 and go to NEXT.
REQ-017 In NEXT with COUNT==1, the block SHALL set busy=0 and go to IDLE, holding a13_a0 at the last address.
REQ-018 In NEXT with COUNT>1, the block SHALL increment a13_a0 by 1 (14-bit modulo), decrement COUNT and go to READ.
REQ-019 The handshake SHALL be four-phase: dav_ falls only while rfd=1, dav_ rises only after rfd=0 has been observed, and dato SHALL be constant whenever dav_=0.
REQ-020 The minimum cost SHALL be 4 cycles per sample when the consumer responds in the same cycle; from start to the first dav_ falling edge SHALL take 3 rising edges with rfd=1.
REQ-021 start SHALL be ignored when it is not in IDLE; changes to enne SHALL be ignored while busy=1.
REQ-022 With base {enne,10'b0} and NumCampioni≤1024, the addresses SHALL never leave block enne; the last address SHALL be base+NumCampioni-1.
REQ-023 When start=1 occurs in the same cycle that NEXT returns to IDLE, it SHALL be ignored; a new block is accepted only from a cycle spent in IDLE.

Reset
REQ-024 On any rising edge with reset=1, in any state, the block SHALL force IDLE, dav_=1, busy=0, dato=8'h00, a13_a0=14'h0000 and COUNT=NumCampioni.
REQ-025 reset SHALL take priority over start and over rfd in the same cycle.
REQ-026 If reset is applied mid-transfer with dav_=0, dav_ SHALL be 1 after that edge, and no partial block SHALL resume afterwards.

Verification
REQ-027 Bench scenario: reset, then enne=4'h3, a 1-cycle start pulse, and an always-ready consumer (rfd rises 1 cycle after dav_ rises and drops 1 cycle after dav_ falls) -> the block delivers 1024 bytes equal to mem[0x0C00..0x0FFF] in order, after which busy=0 and a13_a0=14'h0FFF.
REQ-028 Bench scenario: a consumer that delays rfd=1 by 5 cycles and holds rfd=1 for 3 cycles after dav_ falls -> dav_ stays 1 for those 5 cycles, dato does not change while dav_=0, and no sample is lost or duplicated.
REQ-029 Bench scenario: NumCampioni=4, enne=4'hF and memory data = low address byte -> the block transmits 00,01,02,03 from addresses 0x3C00..0x3C03, and busy falls in the NEXT cycle after the 4th handshake.
REQ-030 Bench scenario: start pulsed again at sample 10 with enne changed -> it has no effect, and the addresses continue in the original block.
REQ-031 Bench scenario: reset asserted in WAITACK with dav_=0 -> after the next edge dav_=1, busy=0 and a13_a0=0; a subsequent start restarts at sample 0 of the new enne.
REQ-032 Bench scenario: reset and start asserted in the same cycle -> the block remains in IDLE with busy=0.
